// File: rtl/mode_counter.sv
// mode_counter: up/down counter over 0..limit with a prescaler,
// wrap/saturate/one-shot terminal modes, a tc pulse and a done flag.
module mode_counter #(
    parameter int               WIDTH       = 8,
    parameter int               PRESCALE_W  = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic                  clear,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_value,
    input  logic                  up,
    input  logic [1:0]            mode,
    input  logic [WIDTH-1:0]      limit,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [WIDTH-1:0]      cnt,
    output logic                  tc,
    output logic                  done
);

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_WRAP2   = 2'b11
    } mode_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_e;

    localparam logic [WIDTH-1:0]      CNT_ONE = WIDTH'(1);
    localparam logic [PRESCALE_W-1:0] PSC_ONE = PRESCALE_W'(1);

    logic [WIDTH-1:0]      cnt_q;
    logic [WIDTH-1:0]      cnt_d;
    logic [PRESCALE_W-1:0] psc_q;
    logic [PRESCALE_W-1:0] psc_d;
    logic                  tc_q;
    logic                  tc_d;
    state_e                state_q;
    state_e                state_d;

    mode_e                 mode_s;
    logic                  psc_hit;
    logic                  tick;
    logic                  above;
    logic                  at_term;
    logic                  sync_reset;
    logic [WIDTH-1:0]      clipped;

    assign mode_s     = mode_e'(mode);
    assign sync_reset = clear | load;

    // A tick needs an enabled cycle with the prescaler at its setting;
    // once done is set the counter ignores ticks entirely.
    assign psc_hit = en & (psc_q == prescale);
    assign tick    = psc_hit & (state_q == ST_RUN);

    // Up direction treats anything at or above limit as terminal,
    // so a run-time lowered limit still wraps/saturates cleanly.
    assign above   = (cnt_q > limit);
    assign at_term = up ? (cnt_q >= limit) : (cnt_q == '0);
    assign clipped = (load_value > limit) ? limit : load_value;

    // Prescaler: free-runs on enabled cycles, restarts on clear/load.
    always_comb begin
        psc_d = psc_q;
        if (sync_reset) begin
            psc_d = '0;
        end else if (en) begin
            if (psc_hit) begin
                psc_d = '0;
            end else begin
                psc_d = psc_q + PSC_ONE;
            end
        end
    end

    // Count next-value: clear beats load beats tick.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = clipped;
        end else if (tick) begin
            if (at_term) begin
                unique case (mode_s)
                    MODE_WRAP,
                    MODE_WRAP2: cnt_d = up ? '0 : limit;
                    MODE_SAT:   cnt_d = cnt_q;
                    MODE_ONESHOT: cnt_d = cnt_q;
                    default:    cnt_d = cnt_q;
                endcase
            end else if (!up && above) begin
                cnt_d = limit;
            end else if (up) begin
                cnt_d = cnt_q + CNT_ONE;
            end else begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end
    end

    // Terminal-count pulse lands with the post-terminal count value.
    always_comb begin
        tc_d = 1'b0;
        if (!sync_reset) begin
            tc_d = tick & at_term;
        end
    end

    // One-shot state: done latches on a terminal tick in one-shot mode
    // and drops on clear/load or when the mode moves away from one-shot.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN: begin
                if (!sync_reset && tick && at_term &&
                    mode_s == MODE_ONESHOT) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (sync_reset || mode_s != MODE_ONESHOT) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // State register; reset forces everything at once, no edge needed.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= RESET_VALUE;
            psc_q   <= '0;
            tc_q    <= 1'b0;
            state_q <= ST_RUN;
        end else begin
            cnt_q   <= cnt_d;
            psc_q   <= psc_d;
            tc_q    <= tc_d;
            state_q <= state_d;
        end
    end

    assign cnt  = cnt_q;
    assign tc   = tc_q;
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_mode_counter.sv
// tb_mode_counter: directed checks for mode_counter
// (default instance plus a RESET_VALUE=7 instance for reset tests).
module tb_mode_counter;

    logic       clock;
    logic       reset_n;
    logic       en;
    logic       clear;
    logic       load;
    logic [7:0] load_value;
    logic       up;
    logic [1:0] mode;
    logic [7:0] limit;
    logic [3:0] prescale;
    logic [7:0] cnt;
    logic       tc;
    logic       done;
    logic [7:0] cnt7;
    logic       tc7;
    logic       done7;

    int checks;
    int passes;

    mode_counter dut (
        .clock(clock), .reset_n(reset_n), .en(en),
        .clear(clear), .load(load), .load_value(load_value),
        .up(up), .mode(mode), .limit(limit),
        .prescale(prescale),
        .cnt(cnt), .tc(tc), .done(done)
    );

    mode_counter #(.RESET_VALUE(8'd7)) dut7 (
        .clock(clock), .reset_n(reset_n), .en(en),
        .clear(clear), .load(load), .load_value(load_value),
        .up(up), .mode(mode), .limit(limit),
        .prescale(prescale),
        .cnt(cnt7), .tc(tc7), .done(done7)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        en = 1'b0; clear = 1'b0; load = 1'b0;
        load_value = 8'd0; up = 1'b1; mode = 2'b00;
        limit = 8'd9; prescale = 4'd0;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (cnt !== 8'd0)
            $display("FAIL reset_cnt got %0d want 0", cnt);
        else passes++;
        checks++;
        if (tc !== 1'b0 || done !== 1'b0)
            $display("FAIL reset_flags got tc=%b done=%b want 0 0",
                     tc, done);
        else passes++;
        checks++;
        if (cnt7 !== 8'd7)
            $display("FAIL reset_cnt7 got %0d want 7", cnt7);
        else passes++;
        step();
        step();
        checks++;
        if (cnt !== 8'd0 || cnt7 !== 8'd7)
            $display("FAIL reset_hold got %0d/%0d want 0/7",
                     cnt, cnt7);
        else passes++;
        en = 1'b1;
        reset_n = 1'b1;
    endtask

    task automatic test_wrap();
        logic [7:0] ec;
        logic       et;
        for (int k = 1; k <= 11; k++) begin
            step();
            ec = 8'(k % 10);
            et = (k == 10);
            checks++;
            if (cnt !== ec)
                $display("FAIL wrap_cnt[%0d] got %0d want %0d",
                         k, cnt, ec);
            else passes++;
            checks++;
            if (tc !== et)
                $display("FAIL wrap_tc[%0d] got %b want %b",
                         k, tc, et);
            else passes++;
        end
    endtask

    task automatic test_prescale();
        logic [7:0] ec;
        prescale = 4'd2;
        clear = 1'b1;
        step();
        clear = 1'b0;
        checks++;
        if (cnt !== 8'd0)
            $display("FAIL psc_clear got %0d want 0", cnt);
        else passes++;
        for (int k = 1; k <= 4; k++) begin
            step();
            ec = (k >= 3) ? 8'd1 : 8'd0;
            checks++;
            if (cnt !== ec)
                $display("FAIL psc_cnt[%0d] got %0d want %0d",
                         k, cnt, ec);
            else passes++;
        end
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (cnt !== 8'd1 || tc !== 1'b0)
                $display("FAIL psc_frozen[%0d] got %0d want 1",
                         k, cnt);
            else passes++;
        end
        en = 1'b1;
        step();
        checks++;
        if (cnt !== 8'd1)
            $display("FAIL psc_resume1 got %0d want 1", cnt);
        else passes++;
        step();
        checks++;
        if (cnt !== 8'd2)
            $display("FAIL psc_resume2 got %0d want 2", cnt);
        else passes++;
    endtask

    task automatic test_saturate();
        logic [7:0] ec;
        logic       et;
        prescale = 4'd0;
        mode = 2'b01;
        up = 1'b0;
        load_value = 8'd3;
        load = 1'b1;
        step();
        load = 1'b0;
        checks++;
        if (cnt !== 8'd3 || tc !== 1'b0)
            $display("FAIL sat_load got %0d tc=%b want 3 0", cnt, tc);
        else passes++;
        for (int k = 0; k < 5; k++) begin
            step();
            ec = (k < 3) ? 8'(2 - k) : 8'd0;
            et = (k >= 3);
            checks++;
            if (cnt !== ec || tc !== et)
                $display("FAIL sat[%0d] got %0d tc=%b want %0d %b",
                         k, cnt, tc, ec, et);
            else passes++;
        end
    endtask

    task automatic test_oneshot();
        mode = 2'b10;
        up = 1'b1;
        limit = 8'd4;
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            checks++;
            if (cnt !== 8'(k) || tc !== 1'b0 || done !== 1'b0)
                $display("FAIL os_run[%0d] got %0d tc=%b done=%b",
                         k, cnt, tc, done);
            else passes++;
        end
        step();
        checks++;
        if (cnt !== 8'd4 || tc !== 1'b1 || done !== 1'b1)
            $display("FAIL os_term got %0d tc=%b done=%b want 4 1 1",
                     cnt, tc, done);
        else passes++;
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if (cnt !== 8'd4 || tc !== 1'b0 || done !== 1'b1)
                $display("FAIL os_held[%0d] got %0d tc=%b done=%b",
                         k, cnt, tc, done);
            else passes++;
        end
        load_value = 8'd1;
        load = 1'b1;
        step();
        load = 1'b0;
        checks++;
        if (cnt !== 8'd1 || done !== 1'b0 || tc !== 1'b0)
            $display("FAIL os_reload got %0d done=%b want 1 0",
                     cnt, done);
        else passes++;
        step();
        checks++;
        if (cnt !== 8'd2)
            $display("FAIL os_resume got %0d want 2", cnt);
        else passes++;
        step();
        step();
        step();
        checks++;
        if (done !== 1'b1 || tc !== 1'b1)
            $display("FAIL os_done2 got done=%b tc=%b want 1 1",
                     done, tc);
        else passes++;
        mode = 2'b00;
        step();
        checks++;
        if (done !== 1'b0 || cnt !== 8'd4 || tc !== 1'b0)
            $display("FAIL os_modeexit got done=%b cnt=%0d tc=%b",
                     done, cnt, tc);
        else passes++;
        step();
        checks++;
        if (cnt !== 8'd0 || tc !== 1'b1)
            $display("FAIL os_wrapafter got %0d tc=%b want 0 1",
                     cnt, tc);
        else passes++;
    endtask

    task automatic test_clip();
        mode = 2'b00;
        up = 1'b1;
        limit = 8'd9;
        load_value = 8'd5;
        clear = 1'b1;
        load = 1'b1;
        step();
        clear = 1'b0;
        checks++;
        if (cnt !== 8'd0)
            $display("FAIL prio_clear got %0d want 0", cnt);
        else passes++;
        load_value = 8'd200;
        step();
        checks++;
        if (cnt !== 8'd9)
            $display("FAIL clip_load got %0d want 9", cnt);
        else passes++;
        load_value = 8'd8;
        step();
        load = 1'b0;
        limit = 8'd5;
        step();
        checks++;
        if (cnt !== 8'd0 || tc !== 1'b1)
            $display("FAIL lower_up got %0d tc=%b want 0 1", cnt, tc);
        else passes++;
        limit = 8'd9;
        load = 1'b1;
        step();
        load = 1'b0;
        limit = 8'd5;
        up = 1'b0;
        step();
        checks++;
        if (cnt !== 8'd5 || tc !== 1'b0)
            $display("FAIL lower_dn got %0d tc=%b want 5 0", cnt, tc);
        else passes++;
        step();
        checks++;
        if (cnt !== 8'd4)
            $display("FAIL lower_dn2 got %0d want 4", cnt);
        else passes++;
    endtask

    task automatic test_limit_zero();
        limit = 8'd0;
        mode = 2'b00;
        up = 1'b1;
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if (cnt !== 8'd0 || tc !== 1'b1)
                $display("FAIL lim0_wrap[%0d] got %0d tc=%b",
                         k, cnt, tc);
            else passes++;
        end
        mode = 2'b10;
        clear = 1'b1;
        step();
        clear = 1'b0;
        step();
        checks++;
        if (tc !== 1'b1 || done !== 1'b1)
            $display("FAIL lim0_os got tc=%b done=%b want 1 1",
                     tc, done);
        else passes++;
        step();
        checks++;
        if (tc !== 1'b0 || done !== 1'b1 || cnt !== 8'd0)
            $display("FAIL lim0_os2 got %0d tc=%b done=%b",
                     cnt, tc, done);
        else passes++;
    endtask

    task automatic test_async_reset();
        mode = 2'b00;
        up = 1'b1;
        limit = 8'd9;
        prescale = 4'd1;
        clear = 1'b1;
        step();
        clear = 1'b0;
        step();
        step();
        step();
        checks++;
        if (cnt7 !== 8'd1)
            $display("FAIL ar_pre got %0d want 1", cnt7);
        else passes++;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (cnt7 !== 8'd7 || tc7 !== 1'b0 || done7 !== 1'b0)
            $display("FAIL ar_now got %0d tc=%b done=%b want 7 0 0",
                     cnt7, tc7, done7);
        else passes++;
        checks++;
        if (cnt !== 8'd0)
            $display("FAIL ar_now0 got %0d want 0", cnt);
        else passes++;
        #1 reset_n = 1'b1;
        step();
        checks++;
        if (cnt7 !== 8'd7 || cnt !== 8'd0)
            $display("FAIL ar_rel1 got %0d/%0d want 7/0", cnt7, cnt);
        else passes++;
        step();
        checks++;
        if (cnt7 !== 8'd8 || cnt !== 8'd1)
            $display("FAIL ar_rel2 got %0d/%0d want 8/1", cnt7, cnt);
        else passes++;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        test_reset();
        test_wrap();
        test_prescale();
        test_saturate();
        test_oneshot();
        test_clip();
        test_limit_zero();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
